// File: rtl/intro_qsys_timer_master.sv
// Avalon-MM initiator that programs, acknowledges and snapshots one interval-timer slave.
// state     | meaning
// IDLE      | timer not owned by a sequence, waiting for cmd_start
// WR_PL     | write period[15:0] to address 2
// WR_PH     | write period[31:16] to address 3
// WR_START  | write START control word to address 1
// RUN       | timer counting, arbitrate stop / irq / snapshot
// ACK       | clear TO in status, report tick
// SNAP_WR   | write address 4 to latch the slave counter
// SNAP_RL   | read snapshot low half
// SNAP_RH   | read snapshot high half, capture low half
// SNAP_DONE | capture high half, report snapshot
// WR_STOP   | write STOP control word to address 1
module intro_qsys_timer_master #(
  parameter bit CONTINUOUS = 1'b1,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_snap,
  input  logic [31:0]        cfg_period,
  input  logic               timer_irq,
  output logic [2:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [15:0]        avm_writedata,
  input  logic [15:0]        avm_readdata,
  output logic               busy,
  output logic               running,
  output logic               tick,
  output logic [COUNT_W-1:0] tick_count,
  output logic               snap_valid,
  output logic [31:0]        snap_value,
  output logic               cfg_err
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_START, RUN, ACK,
    SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE, WR_STOP
  } state_t;

  localparam logic [15:0] CTRL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  state_t      state, state_next;
  logic [31:0] period_q;
  logic        stop_pend, snap_pend;
  logic        start_req, start_bad, start_ok;
  logic        bus_cs_d, bus_wr_n_d;
  logic [2:0]  bus_addr_d;
  logic [15:0] bus_data_d;

  assign start_req = (state == IDLE) && cmd_start;
  assign start_bad = start_req && (cfg_period < 32'd8);
  assign start_ok  = start_req && !start_bad;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_ok) state_next = WR_PL;
      WR_PL:     state_next = WR_PH;
      WR_PH:     state_next = WR_START;
      WR_START:  state_next = RUN;
      RUN: begin
        if (stop_pend)      state_next = WR_STOP;
        else if (timer_irq) state_next = ACK;
        else if (snap_pend) state_next = SNAP_WR;
      end
      ACK:       state_next = CONTINUOUS ? RUN : IDLE;
      SNAP_WR:   state_next = SNAP_RL;
      SNAP_RL:   state_next = SNAP_RH;
      SNAP_RH:   state_next = SNAP_DONE;
      SNAP_DONE: state_next = RUN;
      WR_STOP:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bus values belong to the state being entered so the registered bus lines up with it.
  always_comb begin
    bus_cs_d   = 1'b0;
    bus_wr_n_d = 1'b1;
    bus_addr_d = 3'd0;
    bus_data_d = 16'h0000;
    case (state_next)
      WR_PL:    begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd2; bus_data_d = cfg_period[15:0]; end
      WR_PH:    begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd3; bus_data_d = period_q[31:16]; end
      WR_START: begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd1; bus_data_d = CTRL_START; end
      ACK:      begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd0; end
      SNAP_WR:  begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd4; end
      SNAP_RL:  begin bus_cs_d = 1'b1; bus_addr_d = 3'd4; end
      SNAP_RH:  begin bus_cs_d = 1'b1; bus_addr_d = 3'd5; end
      WR_STOP:  begin bus_cs_d = 1'b1; bus_wr_n_d = 1'b0; bus_addr_d = 3'd1; bus_data_d = CTRL_STOP; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
      period_q       <= 32'd0;
      stop_pend      <= 1'b0;
      snap_pend      <= 1'b0;
      running        <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_valid     <= 1'b0;
      snap_value     <= 32'd0;
      cfg_err        <= 1'b0;
    end else begin
      avm_chipselect <= bus_cs_d;
      avm_write_n    <= bus_wr_n_d;
      avm_address    <= bus_addr_d;
      avm_writedata  <= bus_data_d;
      tick           <= (state_next == ACK);
      snap_valid     <= (state == SNAP_DONE);
      cfg_err        <= start_bad;

      if (start_ok) begin
        period_q   <= cfg_period;
        tick_count <= '0;
      end else if (state_next == ACK) begin
        tick_count <= tick_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end

      if (state == WR_START)
        running <= 1'b1;
      else if ((state == WR_STOP) || ((state == ACK) && !CONTINUOUS))
        running <= 1'b0;

      // Slave read data trails the address by one cycle.
      if (state == SNAP_RH)   snap_value[15:0]  <= avm_readdata;
      if (state == SNAP_DONE) snap_value[31:16] <= avm_readdata;

      if (state_next == IDLE) begin
        stop_pend <= 1'b0;
        snap_pend <= 1'b0;
      end else begin
        if ((state == RUN) && (state_next == WR_STOP))
          stop_pend <= 1'b0;
        else if (cmd_stop && ((state != IDLE) || start_ok))
          stop_pend <= 1'b1;

        if ((state == RUN) && (state_next == SNAP_WR))
          snap_pend <= 1'b0;
        else if (cmd_snap && (state != IDLE))
          snap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intro_qsys_timer_master.sv
// Directed bench: three initiators (periodic, one-shot, narrow counter) each driving an interval-timer model.
module tb_intro_qsys_timer_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  cmd_start, cmd_stop, cmd_snap;
  logic [31:0] cfg_period;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam bit CONT = (g != 1);
    localparam int CW   = (g == 2) ? 4 : 16;
    logic [2:0]    addr;
    logic          cs, wr_n;
    logic [15:0]   wdata, rdata;
    logic          busy, running, tick, snap_valid, cfg_err, timer_irq;
    logic [CW-1:0] tick_count;
    logic [31:0]   snap_value;
    logic [31:0]   period, counter, snap;
    logic          to, run, ito, cont, fr;

    intro_qsys_timer_master #(.CONTINUOUS(CONT), .COUNT_W(CW)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_start(cmd_start[g]), .cmd_stop(cmd_stop[g]), .cmd_snap(cmd_snap[g]),
      .cfg_period(cfg_period), .timer_irq(timer_irq),
      .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wr_n),
      .avm_writedata(wdata), .avm_readdata(rdata),
      .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
      .snap_valid(snap_valid), .snap_value(snap_value), .cfg_err(cfg_err)
    );

    assign timer_irq = to & ito;

    // Interval timer: period writes stop it and force a reload; timeout every period+1 cycles.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        period <= 32'd0; counter <= 32'd0; snap <= 32'd0; rdata <= 16'h0000;
        to <= 1'b0; run <= 1'b0; ito <= 1'b0; cont <= 1'b0; fr <= 1'b0;
      end else begin
        if (fr) begin
          counter <= period;
          fr      <= 1'b0;
        end else if (run) begin
          if (counter == 32'd0) begin
            to      <= 1'b1;
            counter <= period;
            if (!cont) run <= 1'b0;
          end else begin
            counter <= counter - 32'd1;
          end
        end
        if (cs && !wr_n) begin
          case (addr)
            3'd0: to <= 1'b0;
            3'd1: begin
              ito  <= wdata[0];
              cont <= wdata[1];
              if (wdata[2]) run <= 1'b1;
              if (wdata[3]) run <= 1'b0;
            end
            3'd2: begin period[15:0]  <= wdata; fr <= 1'b1; run <= 1'b0; end
            3'd3: begin period[31:16] <= wdata; fr <= 1'b1; run <= 1'b0; end
            3'd4: snap <= counter;
            default: ;
          endcase
        end
        if (cs && wr_n) begin
          case (addr)
            3'd0:    rdata <= {14'b0, run, to};
            3'd1:    rdata <= {14'b0, cont, ito};
            3'd2:    rdata <= period[15:0];
            3'd3:    rdata <= period[31:16];
            3'd4:    rdata <= snap[15:0];
            3'd5:    rdata <= snap[31:16];
            default: rdata <= 16'h0000;
          endcase
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] bus_word(input logic c, input logic w, input logic [2:0] a,
                                           input logic [15:0] d);
    return {11'b0, c, w, a, d};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ticks, cnt;
    int tcyc [3];

    reset_n = 1'b0; cmd_start = '0; cmd_stop = '0; cmd_snap = '0; cfg_period = 32'd0;
    cyc(3);
    chk("rst_bus",      bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b0, 1'b1, 3'd0, 16'h0));
    chk("rst_busy",     32'(gi[0].busy), 32'd0);
    chk("rst_running",  32'(gi[0].running), 32'd0);
    chk("rst_tick_cnt", 32'(gi[0].tick_count), 32'd0);
    chk("rst_snap",     gi[0].snap_value, 32'd0);
    chk("rst_cfg_err",  32'(gi[0].cfg_err), 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // start latency and write sequence with a long period
    cfg_period = 32'h0007_A11F; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    chk("wr_pl",   bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd2, 16'hA11F));
    chk("busy_pl", 32'(gi[0].busy), 32'd1);
    cyc(1);
    chk("wr_ph",   bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd3, 16'h0007));
    cyc(1);
    chk("wr_ctl",  bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd1, 16'h0007));
    chk("run_before_start", 32'(gi[0].running), 32'd0);
    cyc(1);
    chk("run_after_start",  32'(gi[0].running), 32'd1);
    chk("bus_idle_run", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b0, 1'b1, 3'd0, 16'h0));
    cmd_stop[0] = 1'b1;
    cyc(1); cmd_stop[0] = 1'b0;
    cyc(1);
    chk("wr_stop", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd1, 16'h0008));
    cyc(1);
    chk("stop_running", 32'(gi[0].running), 32'd0);
    chk("stop_busy",    32'(gi[0].busy), 32'd0);

    // rejected periods
    cfg_period = 32'd5; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    chk("err_pulse", 32'(gi[0].cfg_err), 32'd1);
    chk("err_busy",  32'(gi[0].busy), 32'd0);
    chk("err_cs",    32'(gi[0].cs), 32'd0);
    cyc(1);
    chk("err_one_cycle", 32'(gi[0].cfg_err), 32'd0);
    cfg_period = 32'd7; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    chk("err_p7", 32'(gi[0].cfg_err), 32'd1);
    cyc(1);

    // periodic ticks, period 99 -> timeout every 100 cycles
    cfg_period = 32'd99; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    ticks = 0; cnt = 0;
    while (ticks < 3 && cnt < 1000) begin
      cyc(1); cnt++;
      if (gi[0].tick) begin
        tcyc[ticks] = cnt;
        if (ticks == 0)
          chk("ack_bus", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd0, 16'h0));
        ticks++;
      end
    end
    chk("ticks_seen", 32'(ticks), 32'd3);
    chk("interval_1", 32'(tcyc[1] - tcyc[0]), 32'd100);
    chk("interval_2", 32'(tcyc[2] - tcyc[1]), 32'd100);
    chk("tick_cnt_3", 32'(gi[0].tick_count), 32'd3);
    cyc(1);
    chk("tick_one_cycle", 32'(gi[0].tick), 32'd0);
    chk("irq_cleared",    32'(gi[0].timer_irq), 32'd0);
    chk("ack_back_run",   bus_word(gi[0].cs, gi[0].wr_n, {2'b0, gi[0].busy}, 16'h0), bus_word(1'b0, 1'b1, 3'd1, 16'h0));

    // snapshot request coinciding with irq
    cnt = 0;
    while (!gi[0].timer_irq && cnt < 200) begin cyc(1); cnt++; end
    chk("irq_seen", 32'(gi[0].timer_irq), 32'd1);
    cmd_snap[0] = 1'b1;
    cyc(1); cmd_snap[0] = 1'b0;
    chk("ack_first", 32'(gi[0].tick), 32'd1);
    chk("ack_first_bus", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd0, 16'h0));
    cyc(1);
    chk("snap_gap", 32'(gi[0].cs), 32'd0);
    cyc(1);
    chk("snap_wr", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd4, 16'h0));
    cyc(1);
    chk("snap_rl", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b1, 3'd4, 16'h0));
    cyc(1);
    chk("snap_rh", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b1, 3'd5, 16'h0));
    cyc(1);
    chk("snap_early", 32'(gi[0].snap_valid), 32'd0);
    cyc(1);
    chk("snap_valid", 32'(gi[0].snap_valid), 32'd1);
    chk("snap_value", gi[0].snap_value, 32'd96);
    cyc(1);
    chk("snap_one_pulse", 32'(gi[0].snap_valid), 32'd0);
    cmd_stop[0] = 1'b1;
    cyc(1); cmd_stop[0] = 1'b0;
    cnt = 0;
    while (gi[0].busy && cnt < 10) begin cyc(1); cnt++; end
    chk("stop2_idle", 32'(gi[0].busy), 32'd0);

    // one-shot instance, period 20
    cfg_period = 32'd20; cmd_start[1] = 1'b1;
    cyc(1); cmd_start[1] = 1'b0;
    ticks = 0;
    repeat (120) begin cyc(1); if (gi[1].tick) ticks++; end
    chk("oneshot_ticks",   32'(ticks), 32'd1);
    chk("oneshot_running", 32'(gi[1].running), 32'd0);
    chk("oneshot_idle",    32'(gi[1].busy), 32'd0);
    chk("oneshot_irq",     32'(gi[1].timer_irq), 32'd0);
    chk("oneshot_count",   32'(gi[1].tick_count), 32'd1);

    // stop arriving during WR_PH
    cfg_period = 32'd99; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    cyc(1);
    cmd_stop[0] = 1'b1;
    chk("ph_stop_ph",  bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd3, 16'h0));
    cyc(1); cmd_stop[0] = 1'b0;
    chk("ph_stop_ctl", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd1, 16'h0007));
    cyc(1);
    chk("ph_stop_run", 32'(gi[0].running), 32'd1);
    cyc(1);
    chk("ph_stop_wr",  bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b0, 3'd1, 16'h0008));
    cyc(1);
    chk("ph_stop_running", 32'(gi[0].running), 32'd0);
    chk("ph_stop_slave_run", 32'(gi[0].run), 32'd0);

    // narrow counter wrap, minimum accepted period 8
    cfg_period = 32'd8; cmd_start[2] = 1'b1;
    cyc(1); cmd_start[2] = 1'b0;
    chk("p8_accepted", 32'(gi[2].busy), 32'd1);
    ticks = 0; cnt = 0;
    while (ticks < 16 && cnt < 400) begin
      cyc(1); cnt++;
      if (gi[2].tick) begin
        ticks++;
        if (ticks == 15) chk("count_max", 32'(gi[2].tick_count), 32'hF);
      end
    end
    chk("wrap_ticks", 32'(ticks), 32'd16);
    chk("wrap_zero",  32'(gi[2].tick_count), 32'd0);
    cmd_stop[2] = 1'b1;
    cyc(1); cmd_stop[2] = 1'b0;
    cyc(3);

    // reset in the middle of a snapshot read
    cfg_period = 32'd99; cmd_start[0] = 1'b1;
    cyc(1); cmd_start[0] = 1'b0;
    cyc(4);
    cmd_snap[0] = 1'b1;
    cyc(1); cmd_snap[0] = 1'b0;
    cyc(1);
    cyc(1);
    chk("mid_rl", bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b1, 1'b1, 3'd4, 16'h0));
    reset_n = 1'b0;
    cyc(1);
    chk("mid_rst_bus",     bus_word(gi[0].cs, gi[0].wr_n, gi[0].addr, gi[0].wdata), bus_word(1'b0, 1'b1, 3'd0, 16'h0));
    chk("mid_rst_busy",    32'(gi[0].busy), 32'd0);
    chk("mid_rst_running", 32'(gi[0].running), 32'd0);
    chk("mid_rst_valid",   32'(gi[0].snap_valid), 32'd0);
    chk("mid_rst_snap",    gi[0].snap_value, 32'd0);
    chk("mid_rst_tick",    32'(gi[0].tick), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (10) begin cyc(1); if (gi[0].snap_valid || gi[0].cs) cnt++; end
    chk("post_rst_quiet", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
